// File: rtl/ex_muldiv.sv
// ex_muldiv: HI/LO multiply/divide unit for the EX stage.
//   mult/multu  : single-cycle 32x32->64 product into {HI,LO}.
//   div/divu    : 32-iteration restoring divider; stalls IF/ID/EX while running.
//   mthi/mtlo   : direct HI/LO writes from src_a.
// Optional build macro: DIV_ZERO_FAST_EN
//   When defined, a zero divisor finishes at the issue edge (IDLE -> DONE)
//   instead of running the full iteration sequence.
module ex_muldiv #(
  parameter logic [31:0] HILO_RST = 32'h0,
  parameter int          DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_mult,
  input  logic        op_multu,
  input  logic        op_div,
  input  logic        op_divu,
  input  logic        op_mthi,
  input  logic        op_mtlo,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        ex_hold,
  output logic        stallreq_md,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV_RUN = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [4:0] LAST_ITER = 5'(DIV_ITER - 1);

  state_t      state;
  state_t      state_nxt;

  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_d;
  logic [31:0] lo_d;

  // Divider working registers
  logic [4:0]  counter;
  logic [31:0] dvd_q;     // dividend magnitude, shifted out MSB first
  logic [31:0] dvs_q;     // divisor magnitude
  logic [31:0] rem_q;     // partial remainder
  logic [31:0] quot_q;    // partial quotient
  logic [31:0] src_a_q;   // original dividend, returned as HI on divide-by-zero
  logic        q_neg_q;
  logic        r_neg_q;
  logic        dz_q;
  logic        start_div;

  logic        div_req;
  logic        mul_req;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] product;

  logic [32:0] rem_shift;
  logic [32:0] diff;
  logic        ge;
  logic [31:0] rem_step;
  logic [31:0] quot_step;
  logic [31:0] q_final;
  logic [31:0] r_final;

  assign div_req = op_div | op_divu;
  assign mul_req = op_mult | op_multu;

  // Operand magnitudes latched at divide issue; divu uses raw values.
  assign abs_a = (op_div && src_a[31]) ? (-src_a) : src_a;
  assign abs_b = (op_div && src_b[31]) ? (-src_b) : src_b;

  // Single-cycle multiply: sign- or zero-extend to 64 bits, keep the low 64.
  assign mul_a   = {{32{op_mult & src_a[31]}}, src_a};
  assign mul_b   = {{32{op_mult & src_b[31]}}, src_b};
  assign product = mul_a * mul_b;

  // One restoring-divide step. The shifted remainder is kept 33 bits wide so
  // unsigned divisors with bit 31 set compare correctly.
  always_comb begin
    rem_shift = {rem_q, dvd_q[31]};
    diff      = rem_shift - {1'b0, dvs_q};
    ge        = ~diff[32];
    rem_step  = ge ? diff[31:0] : rem_shift[31:0];
    quot_step = {quot_q[30:0], ge};
    q_final   = q_neg_q ? (-quot_step) : quot_step;
    r_final   = r_neg_q ? (-rem_step) : rem_step;
    if (dz_q) begin
      q_final = 32'hFFFF_FFFF;
      r_final = src_a_q;
    end
  end

  // Next-state, stall request and HI/LO write decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt   = state;
    stallreq_md = 1'b0;
    start_div   = 1'b0;
    hi_we       = 1'b0;
    lo_we       = 1'b0;
    hi_d        = hi_q;
    lo_d        = lo_q;
    case (state)
      IDLE: begin
        if (div_req) begin
          // Divide issues regardless of ex_hold: the hold is our own stall.
          stallreq_md = 1'b1;
`ifdef DIV_ZERO_FAST_EN
          if (src_b == 32'h0) begin
            hi_we     = 1'b1;
            lo_we     = 1'b1;
            hi_d      = src_a;
            lo_d      = 32'hFFFF_FFFF;
            state_nxt = DONE;
          end else begin
            start_div = 1'b1;
            state_nxt = DIV_RUN;
          end
`else
          start_div = 1'b1;
          state_nxt = DIV_RUN;
`endif
        end else if (!ex_hold) begin
          if (mul_req) begin
            hi_we = 1'b1;
            lo_we = 1'b1;
            hi_d  = product[63:32];
            lo_d  = product[31:0];
          end else if (op_mthi) begin
            hi_we = 1'b1;
            hi_d  = src_a;
          end else if (op_mtlo) begin
            lo_we = 1'b1;
            lo_d  = src_a;
          end
        end
      end
      DIV_RUN: begin
        stallreq_md = 1'b1;
        if (counter == LAST_ITER) begin
          hi_we     = 1'b1;
          lo_we     = 1'b1;
          hi_d      = r_final;
          lo_d      = q_final;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // One unstalled cycle lets the divide leave EX; ops here are ignored.
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= HILO_RST;
      lo_q <= HILO_RST;
    end else begin
      if (hi_we) hi_q <= hi_d;
      if (lo_we) lo_q <= lo_d;
    end
  end

  // Iteration counter: cleared at issue, advances once per DIV_RUN cycle.
  always_ff @(posedge clk) begin
    if (rst)                    counter <= 5'd0;
    else if (start_div)         counter <= 5'd0;
    else if (state == DIV_RUN)  counter <= counter + 5'd1;
  end

  // Divider operand/partial-result registers.
  always_ff @(posedge clk) begin
    // NOTE: these datapath registers have no reset; they are always loaded
    // at issue before DIV_RUN reads them, and a reset returns to IDLE.
    if (start_div) begin
      dvd_q   <= abs_a;
      dvs_q   <= abs_b;
      rem_q   <= 32'h0;
      quot_q  <= 32'h0;
      src_a_q <= src_a;
      q_neg_q <= op_div & (src_a[31] ^ src_b[31]);
      r_neg_q <= op_div & src_a[31];
      dz_q    <= (src_b == 32'h0);
    end else if (state == DIV_RUN) begin
      dvd_q  <= {dvd_q[30:0], 1'b0};
      rem_q  <= rem_step;
      quot_q <= quot_step;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;
  assign busy = (state == DIV_RUN);

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: self-checking bench for ex_muldiv. A behavioural model built
// from plain 64-bit arithmetic tracks HI/LO and the stall window; a compare
// process checks every output on every falling edge, and directed cases pin
// the model with hand-computed values before a randomized run.
module tb_ex_muldiv;

  typedef enum int {K_NOP, K_MULT, K_MULTU, K_DIV, K_DIVU, K_MTHI, K_MTLO} kind_t;

`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_mult = 1'b0;
  logic        op_multu = 1'b0;
  logic        op_div = 1'b0;
  logic        op_divu = 1'b0;
  logic        op_mthi = 1'b0;
  logic        op_mtlo = 1'b0;
  logic [31:0] src_a = 32'h0;
  logic [31:0] src_b = 32'h0;
  logic        ex_hold = 1'b0;
  logic        stallreq_md;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk         (clk),
    .rst         (rst),
    .op_mult     (op_mult),
    .op_multu    (op_multu),
    .op_div      (op_div),
    .op_divu     (op_divu),
    .op_mthi     (op_mthi),
    .op_mtlo     (op_mtlo),
    .src_a       (src_a),
    .src_b       (src_b),
    .ex_hold     (ex_hold),
    .stallreq_md (stallreq_md),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .busy        (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [63:0] div_model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  function automatic logic [63:0] mul_model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    if (sgn) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      return sp;
    end
    up = {32'h0, a} * {32'h0, b};
    return up;
  endfunction

  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;
  logic [31:0] p_hi = 32'h0;
  logic [31:0] p_lo = 32'h0;
  int          m_run = 0;      // stalled DIV_RUN cycles still to go
  bit          m_done = 1'b0;  // the one release cycle after a divide

  // Model update at each edge from the inputs held over the preceding cycle.
  always @(posedge clk) begin
    logic [63:0] res;
    if (rst) begin
      m_hi   <= 32'h0;
      m_lo   <= 32'h0;
      m_run  <= 0;
      m_done <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_run > 0) begin
      m_run <= m_run - 1;
      if (m_run == 1) begin
        m_hi   <= p_hi;
        m_lo   <= p_lo;
        m_done <= 1'b1;
      end
    end else if (op_div || op_divu) begin
      res = div_model(op_div, src_a, src_b);
      if (FAST && src_b == 32'h0) begin
        m_hi   <= res[63:32];
        m_lo   <= res[31:0];
        m_done <= 1'b1;
      end else begin
        p_hi  <= res[63:32];
        p_lo  <= res[31:0];
        m_run <= 32;
      end
    end else if (!ex_hold) begin
      if (op_mult || op_multu) begin
        res  = mul_model(op_mult, src_a, src_b);
        m_hi <= res[63:32];
        m_lo <= res[31:0];
      end else if (op_mthi) begin
        m_hi <= src_a;
      end else if (op_mtlo) begin
        m_lo <= src_a;
      end
    end
  end

  // Compare process: every output on every falling edge once reset has hit.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("hi_o", hi_o, m_hi);
      check("lo_o", lo_o, m_lo);
      check("stallreq_md", {31'h0, stallreq_md},
            {31'h0, (m_run > 0) || (!m_done && (op_div || op_divu))});
      check("busy", {31'h0, busy}, {31'h0, m_run > 0});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_op(input kind_t k, input logic [31:0] a, input logic [31:0] b);
    op_mult  = (k == K_MULT);
    op_multu = (k == K_MULTU);
    op_div   = (k == K_DIV);
    op_divu  = (k == K_DIVU);
    op_mthi  = (k == K_MTHI);
    op_mtlo  = (k == K_MTLO);
    src_a    = a;
    src_b    = b;
  endtask

  // One-cycle non-divide instruction; leaves the bench at posedge+1 with ops cleared.
  task automatic do_op(input kind_t k, input logic [31:0] a, input logic [31:0] b, input bit hold);
    @(posedge clk); #1;
    set_op(k, a, b);
    ex_hold = hold;
    @(posedge clk); #1;
    set_op(K_NOP, 32'h0, 32'h0);
    ex_hold = 1'b0;
  endtask

  // Divide held in EX until the stall drops (through DONE), then released.
  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b, output int stall_n);
    @(posedge clk); #1;
    set_op(sgn ? K_DIV : K_DIVU, a, b);
    ex_hold = 1'b1;
    stall_n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stallreq_md) stall_n++;
      else break;
    end
    @(posedge clk); #1;
    set_op(K_NOP, 32'h0, 32'h0);
    ex_hold = 1'b0;
  endtask

  function automatic int exp_stall(input logic [31:0] b);
    return (FAST && b == 32'h0) ? 1 : 33;
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    int          st;
    kind_t       k;
    logic [31:0] a, b;

    @(posedge clk); #1;
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_hi", hi_o, 32'h0);
    check("rst_lo", lo_o, 32'h0);
    check("rst_stall", {31'h0, stallreq_md}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Signed multiply -3 * 5
    do_op(K_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
    @(negedge clk);
    check("mult_hi", hi_o, 32'hFFFF_FFFF);
    check("mult_lo", lo_o, 32'hFFFF_FFF1);

    // Multiply under ex_hold must not write
    do_op(K_MULT, 32'd7, 32'd7, 1'b1);
    @(negedge clk);
    check("mult_hold_lo", lo_o, 32'hFFFF_FFF1);

    // Unsigned multiply max * max
    do_op(K_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    check("multu_hi", hi_o, 32'hFFFF_FFFE);
    check("multu_lo", lo_o, 32'h0000_0001);

    do_op(K_MTHI, 32'h1111_2222, 32'h0, 1'b0);
    @(negedge clk);
    check("mthi", hi_o, 32'h1111_2222);

    // Signed divide -7 / 2
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, st);
    check("div_stall", st, 33);
    @(negedge clk);
    check("div_lo", lo_o, 32'hFFFF_FFFD);
    check("div_hi", hi_o, 32'hFFFF_FFFF);

    // Unsigned divide 100 / 7 held through DONE: exactly one divide
    run_div(1'b0, 32'd100, 32'd7, st);
    check("divu_stall", st, 33);
    @(negedge clk);
    check("divu_lo", lo_o, 32'd14);
    check("divu_hi", hi_o, 32'd2);
    check("divu_no_restart", {31'h0, stallreq_md | busy}, 32'h0);

    // Divide by zero, signed
    run_div(1'b1, 32'h1234_5678, 32'h0, st);
    check("dz_stall", st, exp_stall(32'h0));
    @(negedge clk);
    check("dz_lo", lo_o, 32'hFFFF_FFFF);
    check("dz_hi", hi_o, 32'h1234_5678);

    // Divide by zero with a negative dividend
    run_div(1'b1, 32'hFFFF_FFF9, 32'h0, st);
    @(negedge clk);
    check("dzn_hi", hi_o, 32'hFFFF_FFF9);

    // Signed overflow
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, st);
    @(negedge clk);
    check("ovf_lo", lo_o, 32'h8000_0000);
    check("ovf_hi", hi_o, 32'h0);

    // Unsigned divisor with bit 31 set
    run_div(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, st);
    @(negedge clk);
    check("bigdivu_lo", lo_o, 32'h1);
    check("bigdivu_hi", hi_o, 32'h7FFF_FFFE);

    // Reset in DIV_RUN cycle 10 aborts the divide
    @(posedge clk); #1;
    set_op(K_DIV, 32'hFFFF_FF9C, 32'd7);
    ex_hold = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    set_op(K_NOP, 32'h0, 32'h0);
    ex_hold = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_hi", hi_o, 32'h0);
    check("abort_lo", lo_o, 32'h0);
    check("abort_stall", {31'h0, stallreq_md}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    do_op(K_MTLO, 32'hA5A5_A5A5, 32'h0, 1'b0);
    @(negedge clk);
    check("mtlo_after_abort", lo_o, 32'hA5A5_A5A5);

    // Randomized run; the compare process checks every cycle
    for (int i = 0; i < 250; i++) begin
      k = kind_t'($urandom_range(0, 6));
      a = rand_word();
      b = ($urandom_range(0, 5) == 0) ? 32'h0 : rand_word();
      if (k == K_DIV || k == K_DIVU) begin
        run_div(k == K_DIV, a, b, st);
        check("rand_div_stall", st, exp_stall(b));
      end else begin
        do_op(k, a, b, $urandom_range(0, 3) == 0);
      end
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "timeout");
  end

endmodule
